// File: rtl/pcie_fpc_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_fpc_dma_engine
//  Description : PC-to-FPGA DMA channel. Issues block read requests, gathers
//                out-of-order completions into a slot-indexed reorder RAM and
//                streams fully received blocks out in request order.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_fpc_dma_engine #(
    parameter int NBLK_LOG2      = 3,
    parameter int BLK_WORDS_LOG2 = 6,
    parameter int PTR_BITS       = 17
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7-NBLK_LOG2:0]      fifo_number,
    input  logic                      pio_wvalid,
    input  logic [3:0]                pio_addr,
    input  logic [63:0]               pio_wdata,
    input  logic                      rc_valid,
    input  logic [7:0]                rc_tag,
    input  logic [BLK_WORDS_LOG2-1:0] rc_index,
    input  logic [63:0]               rc_data,
    output logic                      rr_valid,
    input  logic                      rr_ready,
    output logic [63:0]               rr_addr,
    output logic [63:0]               o_data,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [31:0]               status,
    output logic                      interrupt,
    output logic                      busy,
    output logic [7:0]                err_count
);

    localparam int c_nblk       = 1 << NBLK_LOG2;
    localparam int c_addr_shift = BLK_WORDS_LOG2 + 3;
    localparam int c_ram_aw     = NBLK_LOG2 + BLK_WORDS_LOG2;
    localparam int c_ram_depth  = 1 << c_ram_aw;
    localparam int c_rptr_bits  = PTR_BITS + BLK_WORDS_LOG2;
    localparam int c_cnt_w      = BLK_WORDS_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                   state_q;
    logic                     busy_q;
    logic [PTR_BITS-1:0]      p_request_q, p_request_d;
    logic [PTR_BITS-1:0]      p_write_q,   p_write_d;
    logic [PTR_BITS-1:0]      p_stop_q,    p_stop_d;
    logic [PTR_BITS-1:0]      p_int_q,     p_int_d;
    logic [c_rptr_bits-1:0]   p_read_q,    p_read_d;
    logic [c_cnt_w-1:0]       cnt_q [c_nblk];
    logic [c_cnt_w-1:0]       cnt_d [c_nblk];
    logic [7:0]               err_count_q, err_count_d;
    logic                     interrupt_q, interrupt_d;
    logic                     rd_valid_q,  rd_valid_d;
    logic [63:0]              rd_data_q;
    logic [63:0]              ram_q [c_ram_depth];
    logic [63:0]              obuf_q [4];
    logic [1:0]               obuf_wptr_q, obuf_wptr_d;
    logic [1:0]               obuf_rptr_q, obuf_rptr_d;
    logic [2:0]               obuf_cnt_q,  obuf_cnt_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [PTR_BITS-1:0]  w_p_rblk;
    logic [PTR_BITS-1:0]  w_req_span;
    logic [PTR_BITS-1:0]  w_outstanding;
    logic [PTR_BITS-1:0]  w_pio_field;
    logic [PTR_BITS-1:0]  w_p_write_inc;
    logic [NBLK_LOG2-1:0] w_rc_slot;
    logic [NBLK_LOG2-1:0] w_head_slot;
    logic [NBLK_LOG2-1:0] w_slot_off;
    logic                 w_abort;
    logic                 w_rr_fire;
    logic                 w_rc_hit;
    logic                 w_in_flight;
    logic                 w_rc_write;
    logic                 w_rc_err;
    logic                 w_release;
    logic                 w_out_en;
    logic                 w_rd_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_unused;

    assign w_flush       = (state_q == ST_FLUSH);
    assign w_p_rblk      = p_read_q[c_rptr_bits-1:BLK_WORDS_LOG2];
    assign w_req_span    = p_request_q - w_p_rblk;
    assign w_outstanding = p_request_q - p_write_q;
    assign w_pio_field   = pio_wdata[PTR_BITS+c_addr_shift-1:c_addr_shift];
    assign w_p_write_inc = p_write_q + PTR_BITS'(1);
    assign w_abort       = pio_wvalid && (pio_addr == 4'd8) && pio_wdata[0] && (state_q == ST_RUN);

    // Request window is bounded by the readout pointer so a slot is never
    // reused before its words have left the reorder RAM.
    assign rr_valid  = (state_q == ST_RUN) && (p_request_q != p_stop_q) &&
                       (w_req_span < PTR_BITS'(c_nblk));
    assign w_rr_fire = rr_valid && rr_ready;
    assign rr_addr   = 64'(p_request_q) << c_addr_shift;

    // Completion acceptance: slot is in flight when its distance from the
    // head slot is below the number of outstanding blocks.
    assign w_rc_slot   = rc_tag[NBLK_LOG2-1:0];
    assign w_head_slot = p_write_q[NBLK_LOG2-1:0];
    assign w_slot_off  = w_rc_slot - w_head_slot;
    assign w_in_flight = {{(PTR_BITS-NBLK_LOG2){1'b0}}, w_slot_off} < w_outstanding;
    assign w_rc_hit    = rc_valid && (rc_tag[7:NBLK_LOG2] == fifo_number) && !w_flush;
    assign w_rc_write  = w_rc_hit && w_in_flight;
    assign w_rc_err    = w_rc_hit && !w_in_flight;

    // Head slot full -> release one block per cycle.
    assign w_release = cnt_q[w_head_slot][c_cnt_w-1] && !w_flush;

    // Readout runs only in RUN; an abort squashes everything downstream.
    assign w_out_en   = (state_q == ST_RUN) && !w_abort;
    assign w_rd_issue = w_out_en && (w_p_rblk != p_write_q) &&
                        ((obuf_cnt_q + {2'b00, rd_valid_q}) < 3'd4);
    assign w_push     = rd_valid_q && w_out_en;
    assign w_pop      = o_valid && o_ready;

    assign o_valid   = (obuf_cnt_q != 3'd0);
    assign o_data    = obuf_q[obuf_rptr_q];
    assign status    = 32'(p_write_q) << c_addr_shift;
    assign interrupt = interrupt_q;
    assign busy      = busy_q;
    assign err_count = err_count_q;

    assign w_unused = ^{pio_wdata[63:PTR_BITS+c_addr_shift], pio_wdata[c_addr_shift-1:1]};

    // Next-state computation for pointers, slot counters and output buffer.
    always_comb begin
        p_request_d = p_request_q;
        p_write_d   = p_write_q;
        p_stop_d    = p_stop_q;
        p_int_d     = p_int_q;
        p_read_d    = p_read_q;
        err_count_d = err_count_q;
        interrupt_d = 1'b0;
        rd_valid_d  = w_rd_issue;
        obuf_wptr_d = obuf_wptr_q;
        obuf_rptr_d = obuf_rptr_q;
        obuf_cnt_d  = obuf_cnt_q;

        if (pio_wvalid && (pio_addr == 4'd6)) p_stop_d = w_pio_field;
        if (pio_wvalid && (pio_addr == 4'd7)) p_int_d  = w_pio_field;

        if (w_rr_fire) p_request_d = p_request_q + PTR_BITS'(1);

        if (w_release) begin
            p_write_d   = w_p_write_inc;
            interrupt_d = (w_p_write_inc == p_int_q);
        end

        if (w_rc_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

        for (int s = 0; s < c_nblk; s++) begin
            cnt_d[s] = cnt_q[s];
            if (w_rc_write && (w_rc_slot == NBLK_LOG2'(s))) cnt_d[s] = cnt_q[s] + c_cnt_w'(1);
            if (w_release && (w_head_slot == NBLK_LOG2'(s))) cnt_d[s] = '0;
        end

        if (w_rd_issue) p_read_d = p_read_q + c_rptr_bits'(1);

        if (w_push) obuf_wptr_d = obuf_wptr_q + 2'd1;
        if (w_pop)  obuf_rptr_d = obuf_rptr_q + 2'd1;
        case ({w_push, w_pop})
            2'b10:   obuf_cnt_d = obuf_cnt_q + 3'd1;
            2'b01:   obuf_cnt_d = obuf_cnt_q - 3'd1;
            default: obuf_cnt_d = obuf_cnt_q;
        endcase

        // Outside RUN the output path holds nothing.
        if (!w_out_en) begin
            obuf_wptr_d = 2'd0;
            obuf_rptr_d = 2'd0;
            obuf_cnt_d  = 3'd0;
            rd_valid_d  = 1'b0;
        end

        // FLUSH returns the channel to its post-reset pointer state; p_int
        // is a host setting and survives.
        if (w_flush) begin
            p_request_d = '0;
            p_write_d   = '0;
            p_read_d    = '0;
            p_stop_d    = '0;
            err_count_d = 8'd0;
            interrupt_d = 1'b0;
            for (int s = 0; s < c_nblk; s++) cnt_d[s] = '0;
        end
    end

    // Channel control FSM: RUN -> DRAIN on abort, DRAIN -> FLUSH once idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_abort) begin
                        state_q <= ST_DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (p_write_q == p_request_q) begin
                        state_q <= ST_FLUSH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pointer, counter and output-buffer control registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_request_q <= '0;
            p_write_q   <= '0;
            p_stop_q    <= '0;
            p_int_q     <= '0;
            p_read_q    <= '0;
            err_count_q <= 8'd0;
            interrupt_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            obuf_wptr_q <= 2'd0;
            obuf_rptr_q <= 2'd0;
            obuf_cnt_q  <= 3'd0;
            for (int s = 0; s < c_nblk; s++) cnt_q[s] <= '0;
        end else begin
            p_request_q <= p_request_d;
            p_write_q   <= p_write_d;
            p_stop_q    <= p_stop_d;
            p_int_q     <= p_int_d;
            p_read_q    <= p_read_d;
            err_count_q <= err_count_d;
            interrupt_q <= interrupt_d;
            rd_valid_q  <= rd_valid_d;
            obuf_wptr_q <= obuf_wptr_d;
            obuf_rptr_q <= obuf_rptr_d;
            obuf_cnt_q  <= obuf_cnt_d;
            for (int s = 0; s < c_nblk; s++) cnt_q[s] <= cnt_d[s];
        end
    end

    // Reorder RAM: completion writes by {slot, index}, one-cycle read at p_read.
    always_ff @(posedge clock) begin
        if (w_rc_write) ram_q[{w_rc_slot, rc_index}] <= rc_data;
        rd_data_q <= ram_q[p_read_q[c_ram_aw-1:0]];
    end

    // Output buffer storage; occupancy is tracked by the control registers.
    always_ff @(posedge clock) begin
        if (w_push) obuf_q[obuf_wptr_q] <= rd_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_fpc_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcie_fpc_dma_engine
//  Description : Directed self-checking bench for pcie_fpc_dma_engine with a
//                request-driven scoreboard of expected output words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_fpc_dma_engine;

    localparam logic [4:0] c_fn = 5'h0A;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  fifo_number;
    logic        pio_wvalid;
    logic [3:0]  pio_addr;
    logic [63:0] pio_wdata;
    logic        rc_valid;
    logic [7:0]  rc_tag;
    logic [5:0]  rc_index;
    logic [63:0] rc_data;
    logic        rr_valid;
    logic        rr_ready;
    logic [63:0] rr_addr;
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] status;
    logic        interrupt;
    logic        busy;
    logic [7:0]  err_count;

    int          tests     = 0;
    int          fails     = 0;
    int          model_req = 0;
    int          n_out     = 0;
    int          int_count = 0;
    logic [63:0] last_addr = 64'd0;
    logic [63:0] sb [$];

    pcie_fpc_dma_engine dut (
        .clock       (clock),
        .reset       (reset),
        .fifo_number (fifo_number),
        .pio_wvalid  (pio_wvalid),
        .pio_addr    (pio_addr),
        .pio_wdata   (pio_wdata),
        .rc_valid    (rc_valid),
        .rc_tag      (rc_tag),
        .rc_index    (rc_index),
        .rc_data     (rc_data),
        .rr_valid    (rr_valid),
        .rr_ready    (rr_ready),
        .rr_addr     (rr_addr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .status      (status),
        .interrupt   (interrupt),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mkdata(input int b, input int i);
        return {16'hD0A0, 16'(b), 24'h0, 8'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pio(input logic [3:0] a, input logic [63:0] d);
        pio_wvalid = 1'b1;
        pio_addr   = a;
        pio_wdata  = d;
        tick();
        pio_wvalid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] tag, input int idx, input logic [63:0] d);
        rc_valid = 1'b1;
        rc_tag   = tag;
        rc_index = 6'(idx);
        rc_data  = d;
        tick();
        rc_valid = 1'b0;
    endtask

    task automatic send_block(input int b, input bit rev);
        for (int i = 0; i < 64; i++) begin
            int idx;
            idx      = rev ? (63 - i) : i;
            rc_valid = 1'b1;
            rc_tag   = {c_fn, 3'(b % 8)};
            rc_index = 6'(idx);
            rc_data  = mkdata(b, idx);
            tick();
        end
        rc_valid = 1'b0;
    endtask

    task automatic wait_req(input int n, input int budget);
        int k;
        k = 0;
        while (model_req < n && k < budget) begin
            tick();
            k++;
        end
        check("req_count", 64'(model_req), 64'(n));
    endtask

    task automatic wait_out(input int n, input int budget);
        int k;
        k = 0;
        while (n_out < n && k < budget) begin
            tick();
            k++;
        end
        check("out_count", 64'(n_out), 64'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        sb.delete();
        model_req = 0;
        n_out     = 0;
        int_count = 0;
        reset     = 1'b0;
        tick();
    endtask

    // Scoreboard: each accepted request queues its block's words in order;
    // each output handshake pops and compares.
    always @(negedge clock) begin
        if (!reset) begin
            if (rr_valid && rr_ready) begin
                check("rr_addr", rr_addr, 64'(model_req) << 9);
                last_addr = rr_addr;
                for (int i = 0; i < 64; i++) sb.push_back(mkdata(model_req, i));
                model_req++;
            end
            if (o_valid && o_ready) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL out_unexpected: observed 0x%0h expected no word", o_data);
                end
                if (sb.size() != 0) check("o_data", o_data, sb.pop_front());
                n_out++;
            end
            if (interrupt) begin
                int_count++;
                check("int_status", 64'(status), 64'h600);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        fifo_number = c_fn;
        pio_wvalid  = 1'b0;
        pio_addr    = 4'd0;
        pio_wdata   = 64'd0;
        rc_valid    = 1'b0;
        rc_tag      = 8'd0;
        rc_index    = 6'd0;
        rc_data     = 64'd0;
        rr_ready    = 1'b1;
        o_ready     = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_rr_valid",  64'(rr_valid),  64'd0);
        check("rst_o_valid",   64'(o_valid),   64'd0);
        check("rst_interrupt", 64'(interrupt), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_err",       64'(err_count), 64'd0);
        check("rst_status",    64'(status),    64'd0);

        // Two blocks, in-order completions
        pio(4'd6, 64'(2) << 9);
        wait_req(2, 20);
        repeat (5) tick();
        check("stop2_reqs",     64'(model_req), 64'd2);
        check("stop2_rr_valid", 64'(rr_valid),  64'd0);
        send_block(0, 1'b0);
        send_block(1, 1'b0);
        wait_out(128, 300);
        repeat (3) tick();
        check("status_2blk", 64'(status),   64'h400);
        check("sb_empty_1",  64'(sb.size()), 64'd0);

        // Completion to a slot not in flight, and one for another channel
        send_word({c_fn, 3'd5}, 0, 64'h1234);
        send_word({c_fn ^ 5'h01, 3'd0}, 0, 64'h5678);
        repeat (4) tick();
        check("err_wrong_slot", 64'(err_count), 64'd1);
        check("err_no_output",  64'(n_out),     64'd128);
        check("err_status",     64'(status),    64'h400);

        // Reset mid-session, then a stray completion is an error
        do_reset();
        check("rst2_err",    64'(err_count), 64'd0);
        check("rst2_status", 64'(status),    64'd0);
        send_word({c_fn, 3'd0}, 3, 64'hABCD);
        repeat (2) tick();
        check("err_after_reset", 64'(err_count), 64'd1);

        // Outstanding window limit
        pio(4'd6, 64'(20) << 9);
        pio(4'd7, 64'(3) << 9);
        wait_req(8, 30);
        repeat (10) tick();
        check("window_reqs",     64'(model_req), 64'd8);
        check("window_rr_valid", 64'(rr_valid),  64'd0);
        send_block(0, 1'b0);
        wait_req(9, 200);
        check("addr_9th", last_addr, 64'h1000);
        wait_out(64, 200);

        // Out-of-order slot fill with reversed indices; interrupt at p_write=3
        o_ready = 1'b0;
        send_block(2, 1'b1);
        repeat (4) tick();
        check("ooo_status_hold", 64'(status),  64'h200);
        check("ooo_no_output",   64'(o_valid), 64'd0);
        send_block(1, 1'b1);
        repeat (4) tick();
        check("ooo_status",    64'(status),    64'h600);
        check("ooo_o_valid",   64'(o_valid),   64'd1);
        check("int_once",      64'(int_count), 64'd1);
        o_ready = 1'b1;
        wait_out(192, 400);
        send_block(3, 1'b0);
        wait_out(256, 300);
        repeat (3) tick();
        check("status_4blk",  64'(status),    64'h800);
        check("int_no_again", 64'(int_count), 64'd1);
        check("err_stable",   64'(err_count), 64'd1);

        // Abort with four blocks outstanding
        do_reset();
        pio(4'd6, 64'(6) << 9);
        wait_req(4, 20);
        rr_ready = 1'b0;
        pio(4'd8, 64'd1);
        check("abort_busy",     64'(busy),     64'd1);
        check("abort_rr_valid", 64'(rr_valid), 64'd0);
        sb.delete();
        rr_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            send_block(b, 1'b0);
            tick();
            check("drain_o_valid",  64'(o_valid),  64'd0);
            check("drain_busy",     64'(busy),     64'd1);
            check("drain_rr_valid", 64'(rr_valid), 64'd0);
        end
        send_block(3, 1'b0);
        begin
            int k;
            k = 0;
            while (busy && k < 20) begin
                tick();
                k++;
            end
        end
        check("flush_busy",   64'(busy),      64'd0);
        check("flush_status", 64'(status),    64'd0);
        check("drain_reqs",   64'(model_req), 64'd4);
        check("drain_err",    64'(err_count), 64'd0);
        check("drain_nout",   64'(n_out),     64'd0);

        // Back in RUN with pointers cleared
        model_req = 0;
        pio(4'd6, 64'(1) << 9);
        wait_req(1, 20);
        check("run_addr", last_addr, 64'h0);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
